expm1alpha_fp16_arbiter: RTL and testbench

// - Shares one expm1alpha_fp16_top pipeline (alpha*(exp(x)-1), fp16) among NUM_REQ requesters.
// - Round-robin issue of at most one op per cycle; requester ID tracked through the fixed-latency pipe.
// - Per-requester credit-managed response FIFOs, so the shared pipe never stalls on a slow consumer.
// - Sits between the layer sequencers and the single ELU datapath instance.

---
 rtl/expm1alpha_pkg.sv | 23 ++
 rtl/expm1alpha_rsp_fifo.sv | 64 ++++++
 rtl/expm1alpha_fp16_arbiter.sv | 165 ++++++++++++++++
 tb/tb_expm1alpha_fp16_arbiter.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/expm1alpha_pkg.sv
// Shared types and constants for the expm1alpha (alpha*(exp(x)-1)) fp16 datapath wrapper.
// Latency: n/a (types only).
// Backpressure: n/a.
package expm1alpha_pkg;

  typedef logic [15:0] fp16_t;

  localparam int LATENCY_A10 = 11;
  localparam int LATENCY_S10 = 9;

  // Wide enough for the largest supported requester count (8).
  localparam int TAG_ID_W = 3;

  typedef struct packed {
    logic                v;
    logic [TAG_ID_W-1:0] id;
  } tag_t;

  function automatic int latency(input logic board_a10);
    return board_a10 ? LATENCY_A10 : LATENCY_S10;
  endfunction

endpackage

// File: rtl/expm1alpha_rsp_fifo.sv
// Per-requester response FIFO, synchronous, first-word-fall-through.
// Latency: a push is visible at o_dat/o_vld the cycle after it is written.
// Backpressure: none internally; the arbiter's credits guarantee a free slot for every push.
module expm1alpha_rsp_fifo
  import expm1alpha_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = 16
) (
  input  logic         clock,
  input  logic         resetn,
  input  logic         i_push,
  input  logic [W-1:0] i_push_dat,
  input  logic         i_pop,
  output logic         o_vld,
  output logic [W-1:0] o_dat
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] r_mem [DEPTH];
  logic [AW:0]  r_wr_ptr;
  logic [AW:0]  r_rd_ptr;
  logic         w_empty;
  logic         w_full;
  logic         w_do_pop;
  logic         w_do_push;

  assign w_empty   = (r_wr_ptr == r_rd_ptr);
  assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_do_pop  = i_pop & ~w_empty;
  // A push on a full FIFO is only accepted when the head leaves in the same cycle.
  assign w_do_push = i_push & (~w_full | w_do_pop);

  // Pointer update; empty FIFO ignores pops.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Storage write; contents need no reset since the pointers define validity.
  always_ff @(posedge clock) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_push_dat;
  end

  // Head of queue, forced to zero while empty so idle outputs are clean.
  always_comb begin
    o_vld = ~w_empty;
    o_dat = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];
  end

  // Overflow would mean the credit accounting upstream is broken.
  always_ff @(posedge clock) begin
    if (resetn) begin
      a_no_overflow: assert (!(i_push && w_full && !i_pop));
    end
  end

endmodule

// File: rtl/expm1alpha_fp16_arbiter.sv
// Round-robin sharing of one fixed-latency expm1alpha fp16 pipe among NUM_REQ requesters.
// Latency: issue at cycle T -> rsp_valid at T+LATENCY+1 (12 cycles A10, 10 cycles S10).
// Backpressure: credit per requester; a full response FIFO blocks only its own requester, the pipe never stalls.
module expm1alpha_fp16_arbiter
  import expm1alpha_pkg::*;
#(
  parameter int NUM_REQ          = 4,
  parameter int BOARD_FAMILY_A10 = 1,
  parameter int FIFO_DEPTH       = 4
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ*16-1:0] req_x,
  input  logic [NUM_REQ*16-1:0] req_a,
  output logic [NUM_REQ-1:0]    rsp_valid,
  input  logic [NUM_REQ-1:0]    rsp_ready,
  output logic [NUM_REQ*16-1:0] rsp_data,
  output logic                  pipe_ivalid,
  input  logic                  pipe_iready,
  output logic [15:0]           pipe_datain_x,
  output logic [15:0]           pipe_datain_a,
  input  logic                  pipe_ovalid,
  output logic                  pipe_oready,
  input  logic [15:0]           pipe_dataout,
  output logic                  err_sync
);

  localparam int LATENCY = latency(BOARD_FAMILY_A10 != 0);
  localparam int IDW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW      = $clog2(FIFO_DEPTH + 1);

  logic [NUM_REQ-1:0] w_elig;
  logic [NUM_REQ-1:0] w_grant;
  logic [NUM_REQ-1:0] w_pop;
  logic [NUM_REQ-1:0] w_push;
  logic [NUM_REQ-1:0] w_fifo_vld;
  logic [IDW-1:0]     w_gnt_idx;
  logic [IDW-1:0]     w_scan_idx;
  logic               w_found;
  fp16_t              w_mux_x;
  fp16_t              w_mux_a;
  tag_t               w_tag_in;
  tag_t               w_tag_out;

  logic [IDW-1:0]     r_ptr;
  logic [CW-1:0]      r_credit [NUM_REQ];
  tag_t               r_tag [LATENCY];
  logic               r_err_sync;

  // A requester may issue only with a free response slot and a ready pipe; nothing issues in reset.
  always_comb begin
    w_elig = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_elig[i] = resetn & req_valid[i] & (r_credit[i] != '0) & pipe_iready;
    end
  end

  // Round-robin pick: first eligible requester at or after the pointer.
  always_comb begin
    w_grant    = '0;
    w_gnt_idx  = '0;
    w_found    = 1'b0;
    w_scan_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_scan_idx = IDW'((int'(r_ptr) + k) % NUM_REQ);
      if (!w_found && w_elig[w_scan_idx]) begin
        w_found            = 1'b1;
        w_gnt_idx          = w_scan_idx;
        w_grant[w_scan_idx] = 1'b1;
      end
    end
  end

  // One-hot operand mux; zero when nothing is granted.
  always_comb begin
    w_mux_x = '0;
    w_mux_a = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant[i]) begin
        w_mux_x = req_x[16*i +: 16];
        w_mux_a = req_a[16*i +: 16];
      end
    end
  end

  assign req_ready     = w_grant;
  assign pipe_ivalid   = w_found;
  assign pipe_datain_x = w_mux_x;
  assign pipe_datain_a = w_mux_a;
  assign pipe_oready   = 1'b1;
  assign err_sync      = r_err_sync;
  assign rsp_valid     = w_fifo_vld;
  assign w_pop         = rsp_ready & w_fifo_vld;

  // Pointer moves past the winner so it gets lowest priority next cycle.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_ptr <= '0;
    end else if (w_found) begin
      r_ptr <= (w_gnt_idx == IDW'(NUM_REQ - 1)) ? '0 : w_gnt_idx + 1'b1;
    end
  end

  // Credits track free response slots: spent on issue, returned on pop.
  always_ff @(posedge clock) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!resetn) begin
        r_credit[i] <= CW'(FIFO_DEPTH);
      end else if (w_grant[i] && !w_pop[i]) begin
        r_credit[i] <= r_credit[i] - 1'b1;
      end else if (!w_grant[i] && w_pop[i]) begin
        r_credit[i] <= r_credit[i] + 1'b1;
      end
    end
  end

  assign w_tag_in.v  = w_found;
  assign w_tag_in.id = TAG_ID_W'(w_gnt_idx);
  assign w_tag_out   = r_tag[LATENCY-1];

  // Tag shift register mirrors the datapath so each result knows its owner.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      for (int s = 0; s < LATENCY; s++) r_tag[s] <= '0;
    end else begin
      r_tag[0] <= w_tag_in;
      for (int s = 1; s < LATENCY; s++) r_tag[s] <= r_tag[s-1];
    end
  end

  // Results are routed by the tag alone, even if the datapath's valid disagrees.
  always_comb begin
    w_push = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_push[i] = w_tag_out.v & (w_tag_out.id == TAG_ID_W'(i));
    end
  end

  // Sticky flag for any cycle where datapath valid and tag valid differ.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_err_sync <= 1'b0;
    end else if (pipe_ovalid != w_tag_out.v) begin
      r_err_sync <= 1'b1;
    end
  end

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rsp
    expm1alpha_rsp_fifo #(
      .DEPTH (FIFO_DEPTH),
      .W     (16)
    ) u_fifo (
      .clock      (clock),
      .resetn     (resetn),
      .i_push     (w_push[gi]),
      .i_push_dat (pipe_dataout),
      .i_pop      (rsp_ready[gi]),
      .o_vld      (w_fifo_vld[gi]),
      .o_dat      (rsp_data[16*gi +: 16])
    );
  end

endmodule

// File: tb/tb_expm1alpha_fp16_arbiter.sv
// Bench for the shared expm1alpha arbiter with a behavioural 11-cycle datapath stub.
// Latency: n/a.
// Backpressure: driven per scenario through rsp_ready and pipe_iready.
module tb_expm1alpha_fp16_arbiter;

  localparam int NR  = 4;
  localparam int LAT = 11;

  logic          clock = 1'b0;
  logic          resetn = 1'b0;
  logic [NR-1:0] req_valid = '0;
  logic [NR-1:0] req_ready;
  logic [63:0]   req_x = '0;
  logic [63:0]   req_a = '0;
  logic [NR-1:0] rsp_valid;
  logic [NR-1:0] rsp_ready = '1;
  logic [63:0]   rsp_data;
  logic          pipe_ivalid;
  logic          pipe_iready = 1'b1;
  logic [15:0]   pipe_datain_x;
  logic [15:0]   pipe_datain_a;
  logic          pipe_ovalid;
  logic          pipe_oready;
  logic [15:0]   pipe_dataout;
  logic          err_sync;

  int n_checks = 0;
  int n_errors = 0;
  int acc_cnt [NR] = '{default: 0};
  logic [15:0] sb_q [NR][$];

  always #5 clock = ~clock;

  expm1alpha_fp16_arbiter #(
    .NUM_REQ          (NR),
    .BOARD_FAMILY_A10 (1),
    .FIFO_DEPTH       (4)
  ) dut (
    .clock         (clock),
    .resetn        (resetn),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_x         (req_x),
    .req_a         (req_a),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_data      (rsp_data),
    .pipe_ivalid   (pipe_ivalid),
    .pipe_iready   (pipe_iready),
    .pipe_datain_x (pipe_datain_x),
    .pipe_datain_a (pipe_datain_a),
    .pipe_ovalid   (pipe_ovalid),
    .pipe_oready   (pipe_oready),
    .pipe_dataout  (pipe_dataout),
    .err_sync      (err_sync)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Stand-in for the expm1alpha datapath: the golden point plus a cheap mixing function.
  function automatic logic [15:0] ref_elu(input logic [15:0] x, input logic [15:0] a);
    if (x == 16'hBC00 && a == 16'h3C00) return 16'hB90F;
    return x ^ {a[14:0], a[15]} ^ 16'h5A5A;
  endfunction

  // Datapath stub: fixed LAT-cycle pipe, cleared by reset, with an injectable stray valid.
  logic [LAT-1:0] dp_v;
  logic [15:0]    dp_d [LAT];
  logic           force_ov = 1'b0;

  always @(posedge clock) begin
    if (!resetn) begin
      dp_v <= '0;
    end else begin
      dp_v    <= {dp_v[LAT-2:0], pipe_ivalid & pipe_oready};
      dp_d[0] <= ref_elu(pipe_datain_x, pipe_datain_a);
      for (int s = 1; s < LAT; s++) dp_d[s] <= dp_d[s-1];
    end
  end

  assign pipe_ovalid  = dp_v[LAT-1] | force_ov;
  assign pipe_dataout = dp_d[LAT-1];

  // Scoreboard: push on acceptance, pop and compare on consumption.
  always @(negedge clock) begin
    if (resetn) begin
      check_val("grant_onehot", $onehot0(req_ready), 1);
      check_val("ivalid", pipe_ivalid, |req_ready);
      for (int i = 0; i < NR; i++) begin
        if (req_ready[i]) begin
          sb_q[i].push_back(ref_elu(req_x[16*i +: 16], req_a[16*i +: 16]));
          acc_cnt[i]++;
          check_val("datain_x", pipe_datain_x, req_x[16*i +: 16]);
          check_val("datain_a", pipe_datain_a, req_a[16*i +: 16]);
        end
        if (rsp_valid[i] && sb_q[i].size() == 0) begin
          check_val($sformatf("unexp_rsp%0d", i), rsp_valid[i], 0);
        end else if (rsp_valid[i] && rsp_ready[i]) begin
          check_val($sformatf("rsp_data%0d", i), rsp_data[16*i +: 16], sb_q[i].pop_front());
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

  initial begin
    int n;
    int expg;
    int a0;
    int a2;
    logic seen;

    // Reset state with every requester asking.
    req_valid = '1;
    req_x     = {$urandom, $urandom};
    req_a     = {$urandom, $urandom};
    cyc(3);
    @(negedge clock);
    check_val("rst_req_ready", req_ready, 0);
    check_val("rst_rsp_valid", rsp_valid, 0);
    check_val("rst_rsp_data", rsp_data, 0);
    check_val("rst_ivalid", pipe_ivalid, 0);
    check_val("rst_datain", {pipe_datain_x, pipe_datain_a}, 0);
    check_val("rst_err", err_sync, 0);
    check_val("rst_oready", pipe_oready, 1);
    cyc(1);
    resetn    = 1'b1;
    req_valid = '0;
    cyc(2);

    // Golden point and issue-to-response latency.
    req_valid = 4'b0001;
    req_x     = {48'h0, 16'hBC00};
    req_a     = {48'h0, 16'h3C00};
    @(negedge clock);
    check_val("lat_accept", req_ready, 4'b0001);
    cyc(1);
    req_valid = '0;
    n = 0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clock);
      if (rsp_valid[0]) begin
        n = k;
        break;
      end
    end
    check_val("latency", n, 12);
    check_val("golden", rsp_data[15:0], 16'hB90F);
    @(negedge clock);
    check_val("lat_popped", rsp_valid, 0);
    cyc(5);

    // Round robin with all requesters busy; pointer sits at 1 after the single grant to 0.
    req_valid = '1;
    rsp_ready = '1;
    expg = 1;
    for (int c = 0; c < 16; c++) begin
      req_x = {$urandom, $urandom};
      req_a = {$urandom, $urandom};
      @(negedge clock);
      check_val("rr_grant", req_ready, 4'b0001 << expg);
      expg = (expg + 1) % NR;
      cyc(1);
    end

    // Datapath not ready: no issue, pointer held.
    pipe_iready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      check_val("stall_req_ready", req_ready, 0);
      check_val("stall_ivalid", pipe_ivalid, 0);
      cyc(1);
    end
    pipe_iready = 1'b1;
    @(negedge clock);
    check_val("stall_resume", req_ready, 4'b0001 << expg);
    cyc(1);
    req_valid = '0;
    cyc(20);

    // Slow consumer on requester 2: exactly four ops, others keep flowing.
    a0 = acc_cnt[0];
    a2 = acc_cnt[2];
    rsp_ready = 4'b1011;
    req_valid = '1;
    for (int c = 0; c < 40; c++) begin
      req_x = {$urandom, $urandom};
      req_a = {$urandom, $urandom};
      cyc(1);
    end
    check_val("bp_req2_ops", acc_cnt[2] - a2, 4);
    check_val("bp_req0_flow", (acc_cnt[0] - a0) >= 10, 1);
    check_val("bp_rsp2_full", rsp_valid[2], 1);
    @(negedge clock);
    check_val("bp_req2_blocked", req_ready[2], 0);
    cyc(1);
    a2 = acc_cnt[2];
    rsp_ready = '1;
    cyc(30);
    check_val("bp_req2_resumed", (acc_cnt[2] - a2) > 0, 1);
    req_valid = '0;
    cyc(20);

    // Reset with six operations in flight.
    req_valid = '1;
    cyc(6);
    resetn = 1'b0;
    for (int i = 0; i < NR; i++) sb_q[i].delete();
    cyc(1);
    resetn    = 1'b1;
    req_valid = '0;
    @(negedge clock);
    check_val("mid_rst_rsp_valid", rsp_valid, 0);
    seen = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clock);
      seen = seen | (|rsp_valid);
    end
    check_val("mid_rst_no_rsp", seen, 0);
    check_val("mid_rst_err", err_sync, 0);
    cyc(1);
    a0 = acc_cnt[0];
    rsp_ready = 4'b0000;
    req_valid = 4'b0001;
    cyc(30);
    check_val("mid_rst_credits", acc_cnt[0] - a0, 4);
    req_valid = '0;
    rsp_ready = '1;
    cyc(20);

    // Stray datapath valid with no tag in flight.
    check_val("err_pre", err_sync, 0);
    force_ov = 1'b1;
    cyc(1);
    force_ov = 1'b0;
    @(negedge clock);
    check_val("err_set", err_sync, 1);
    cyc(5);
    check_val("err_sticky", err_sync, 1);
    resetn = 1'b0;
    cyc(1);
    resetn = 1'b1;
    @(negedge clock);
    check_val("err_cleared", err_sync, 0);
    cyc(2);

    for (int i = 0; i < NR; i++) begin
      check_val($sformatf("sb_empty%0d", i), sb_q[i].size(), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
